// File: rtl/eth_phy_10g_rx_lock_ctrl_if.sv
// Bundle between the 10G PCS RX block aligner and its lock supervisor.
// All signals are plain levels sampled on clk. There is no valid/ready handshake:
// every i_* signal is taken as-is on each rising edge, and every o_* signal is a
// registered level that is valid from the edge that produced it.
// o_state is a debug view of the supervisor FSM, using the same encoding as the RTL.
interface eth_phy_10g_rx_lock_ctrl_if #(
   parameter int HDR_WIDTH = 2
);
   logic                 i_rx_block_lock;
   logic [HDR_WIDTH-1:0] i_serdes_rx_hdr;
   logic                 i_err_cnt_clr;
   logic                 o_aligner_rst;
   logic                 o_rx_high_ber;
   logic                 o_rx_status;
   logic [7:0]           o_relock_count;
   logic [15:0]          o_err_count;
   logic [1:0]           o_state;

   // aligner / PCS side: drives lock, header and clear; observes status
   modport master (
      output i_rx_block_lock, i_serdes_rx_hdr, i_err_cnt_clr,
      input  o_aligner_rst, o_rx_high_ber, o_rx_status, o_relock_count, o_err_count, o_state
   );

   // supervisor side
   modport slave (
      input  i_rx_block_lock, i_serdes_rx_hdr, i_err_cnt_clr,
      output o_aligner_rst, o_rx_high_ber, o_rx_status, o_relock_count, o_err_count, o_state
   );
endinterface

// File: rtl/eth_phy_10g_rx_lock_ctrl.sv
// 10G PCS RX block-aligner supervisor: sequences the aligner reset, retries
// failed lock attempts after a timeout, and runs the sync-header BER monitor
// that produces rx_high_ber / rx_status.
// Optional feature macro: RX_ERR_CNT_EN (saturating invalid-header counter on
// o_err_count; when undefined o_err_count is constant zero).
module eth_phy_10g_rx_lock_ctrl #(
   parameter int HDR_WIDTH           = 2,
   parameter int BER_WINDOW_CYCLES   = 19531,
   parameter int BER_THRESHOLD       = 16,
   parameter int LOCK_TIMEOUT_CYCLES = 65536,
   parameter int RST_HOLD_CYCLES     = 8,
   parameter int HIBER_RESET_WINDOWS = 8
) (
   input  logic                          clk,
   input  logic                          i_rst,
   eth_phy_10g_rx_lock_ctrl_if.slave     bus
);
   localparam logic [1:0] ST_RESET  = 2'd0;
   localparam logic [1:0] ST_WAIT   = 2'd1;
   localparam logic [1:0] ST_LOCKED = 2'd2;

   localparam int HOLD_W = (RST_HOLD_CYCLES > 1)     ? $clog2(RST_HOLD_CYCLES)     : 1;
   localparam int TO_W   = (LOCK_TIMEOUT_CYCLES > 1) ? $clog2(LOCK_TIMEOUT_CYCLES) : 1;
   localparam int WIN_W  = (BER_WINDOW_CYCLES > 1)   ? $clog2(BER_WINDOW_CYCLES)   : 1;
   localparam int HW_W   = (HIBER_RESET_WINDOWS > 1) ? $clog2(HIBER_RESET_WINDOWS) : 1;
   // ber_cnt has to hold the threshold value itself, since it saturates there
   localparam int BER_W  = $clog2(BER_THRESHOLD + 1);

   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD_CYCLES - 1);
   localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(LOCK_TIMEOUT_CYCLES - 1);
   localparam logic [WIN_W-1:0]  WIN_LAST  = WIN_W'(BER_WINDOW_CYCLES - 1);
   localparam logic [HW_W-1:0]   HW_LAST   = HW_W'(HIBER_RESET_WINDOWS - 1);
   localparam logic [BER_W-1:0]  BER_MAX   = BER_W'(BER_THRESHOLD);

   logic [1:0]        r_state, w_state_nxt;
   logic [HOLD_W-1:0] r_hold_cnt, w_hold_nxt;
   logic [TO_W-1:0]   r_to_cnt, w_to_nxt;
   logic [WIN_W-1:0]  r_win_cnt, w_win_nxt;
   logic [BER_W-1:0]  r_ber_cnt, w_ber_nxt, w_ber_sum;
   logic [HW_W-1:0]   r_hiwin_cnt, w_hiwin_nxt;
   logic              r_hi_ber, w_hi_ber_nxt;
   logic              r_aligner_rst, r_rx_status;
   logic [7:0]        r_relock_cnt;
   logic              w_relock_inc;
   logic              w_invalid;

   // a header only counts while locked and the aligner still claims lock
   assign w_invalid = (r_state == ST_LOCKED) && bus.i_rx_block_lock &&
                      ((bus.i_serdes_rx_hdr == '0) || (bus.i_serdes_rx_hdr == '1));
   assign w_ber_sum = (r_ber_cnt == BER_MAX) ? r_ber_cnt : r_ber_cnt + BER_W'(w_invalid);

   // next-state and counter update; counters not owned by a state fall back to zero
   always_comb begin
      w_state_nxt  = r_state;
      w_hold_nxt   = '0;
      w_to_nxt     = '0;
      w_win_nxt    = '0;
      w_ber_nxt    = '0;
      w_hiwin_nxt  = '0;
      w_hi_ber_nxt = 1'b0;
      w_relock_inc = 1'b0;
      case (r_state)
         ST_RESET: begin
            if (r_hold_cnt == HOLD_LAST) w_state_nxt = ST_WAIT;
            else                         w_hold_nxt  = r_hold_cnt + 1'b1;
         end
         ST_WAIT: begin
            if (bus.i_rx_block_lock) begin
               w_state_nxt = ST_LOCKED;
            end else if (r_to_cnt == TO_LAST) begin
               w_state_nxt  = ST_RESET;
               w_relock_inc = 1'b1;
            end else begin
               w_to_nxt = r_to_cnt + 1'b1;
            end
         end
         ST_LOCKED: begin
            if (!bus.i_rx_block_lock) begin
               // aligner re-slips on its own; just go back to waiting with BER state cleared
               w_state_nxt = ST_WAIT;
            end else begin
               w_hi_ber_nxt = r_hi_ber || (w_ber_sum == BER_MAX);
               if (r_win_cnt == WIN_LAST) begin
                  if (w_ber_sum != BER_MAX) begin
                     w_hi_ber_nxt = 1'b0;
                  end else if (r_hiwin_cnt == HW_LAST) begin
                     w_state_nxt  = ST_RESET;
                     w_relock_inc = 1'b1;
                     w_hi_ber_nxt = 1'b0;
                  end else begin
                     w_hiwin_nxt = r_hiwin_cnt + 1'b1;
                  end
               end else begin
                  w_win_nxt   = r_win_cnt + 1'b1;
                  w_ber_nxt   = w_ber_sum;
                  w_hiwin_nxt = r_hiwin_cnt;
               end
            end
         end
         default: w_state_nxt = ST_RESET;
      endcase
   end

   // state, counters and registered outputs; i_rst overrides everything
   always_ff @(posedge clk) begin
      if (i_rst) begin
         r_state       <= ST_RESET;
         r_hold_cnt    <= '0;
         r_to_cnt      <= '0;
         r_win_cnt     <= '0;
         r_ber_cnt     <= '0;
         r_hiwin_cnt   <= '0;
         r_hi_ber      <= 1'b0;
         r_aligner_rst <= 1'b1;
         r_rx_status   <= 1'b0;
         r_relock_cnt  <= '0;
      end else begin
         r_state       <= w_state_nxt;
         r_hold_cnt    <= w_hold_nxt;
         r_to_cnt      <= w_to_nxt;
         r_win_cnt     <= w_win_nxt;
         r_ber_cnt     <= w_ber_nxt;
         r_hiwin_cnt   <= w_hiwin_nxt;
         r_hi_ber      <= w_hi_ber_nxt;
         r_aligner_rst <= (w_state_nxt == ST_RESET);
         r_rx_status   <= (w_state_nxt == ST_LOCKED) && !w_hi_ber_nxt;
         if (w_relock_inc && (r_relock_cnt != 8'hFF)) r_relock_cnt <= r_relock_cnt + 1'b1;
      end
   end

   assign bus.o_aligner_rst  = r_aligner_rst;
   assign bus.o_rx_high_ber  = r_hi_ber;
   assign bus.o_rx_status    = r_rx_status;
   assign bus.o_relock_count = r_relock_cnt;
   assign bus.o_state        = r_state;

`ifdef RX_ERR_CNT_EN
   logic [15:0] r_err_cnt;

   // saturating invalid-header count; a clear beats a same-cycle increment
   always_ff @(posedge clk) begin
      if (i_rst || bus.i_err_cnt_clr)           r_err_cnt <= '0;
      else if (w_invalid && r_err_cnt != 16'hFFFF) r_err_cnt <= r_err_cnt + 1'b1;
   end

   assign bus.o_err_count = r_err_cnt;
`else
   logic w_unused_clr;
   assign w_unused_clr    = bus.i_err_cnt_clr;
   assign bus.o_err_count = 16'd0;
`endif
endmodule

// File: tb/tb_eth_phy_10g_rx_lock_ctrl.sv
// Bench for eth_phy_10g_rx_lock_ctrl with shortened windows/timeouts.
// Inputs change 1 ns after a rising edge; outputs are checked at that same
// point, i.e. they show the effect of the inputs applied during the previous cycle.
module tb_eth_phy_10g_rx_lock_ctrl;
   localparam logic [1:0] S_RESET  = 2'd0;
   localparam logic [1:0] S_WAIT   = 2'd1;
   localparam logic [1:0] S_LOCKED = 2'd2;
`ifdef RX_ERR_CNT_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   typedef struct {
      logic       rst;
      logic       lock;
      logic [1:0] hdr;
      logic       ar;
      logic       st;
      logic       hb;
      logic [7:0] rc;
      logic [1:0] state;
   } vec_t;

   logic clk = 1'b0;
   logic i_rst = 1'b1;
   int   n_total = 0;
   int   n_bad = 0;
   vec_t vecs[$];

   eth_phy_10g_rx_lock_ctrl_if #(.HDR_WIDTH(2)) bus ();

   eth_phy_10g_rx_lock_ctrl #(
      .HDR_WIDTH(2), .BER_WINDOW_CYCLES(64), .BER_THRESHOLD(16),
      .LOCK_TIMEOUT_CYCLES(128), .RST_HOLD_CYCLES(4), .HIBER_RESET_WINDOWS(2)
   ) dut (
      .clk(clk), .i_rst(i_rst), .bus(bus)
   );

   // clock and reset block
   always #5 clk = ~clk;

   // scoreboard primitive
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic chk_all(input string nm, input logic ar, input logic st, input logic hb,
                          input logic [7:0] rc, input logic [1:0] s);
      chk({nm, ".aligner_rst"}, 32'(bus.o_aligner_rst), 32'(ar));
      chk({nm, ".rx_status"},   32'(bus.o_rx_status),   32'(st));
      chk({nm, ".high_ber"},    32'(bus.o_rx_high_ber), 32'(hb));
      chk({nm, ".relock"},      32'(bus.o_relock_count), 32'(rc));
      chk({nm, ".state"},       32'(bus.o_state),       32'(s));
   endtask

   task automatic chk_err(input string nm, input int v);
      chk({nm, ".err_count"}, 32'(bus.o_err_count), ERR_EN ? 32'(v) : 32'd0);
   endtask

   // driver tasks
   task automatic steps(input int n, input logic lock, input logic [1:0] hdr, input logic clr = 1'b0);
      for (int i = 0; i < n; i++) begin
         bus.i_rx_block_lock = lock;
         bus.i_serdes_rx_hdr = hdr;
         bus.i_err_cnt_clr   = clr;
         @(posedge clk);
         #1;
      end
      bus.i_err_cnt_clr = 1'b0;
   endtask

   task automatic add_vec(input logic rst, input logic lock, input logic [1:0] hdr, input logic ar,
                          input logic st, input logic hb, input logic [7:0] rc, input logic [1:0] s);
      vec_t v;
      v.rst = rst; v.lock = lock; v.hdr = hdr; v.ar = ar;
      v.st = st; v.hb = hb; v.rc = rc; v.state = s;
      vecs.push_back(v);
   endtask

   task automatic apply_vecs(input int lo, input int hi);
      for (int i = lo; i <= hi; i++) begin
         i_rst               = vecs[i].rst;
         bus.i_rx_block_lock = vecs[i].lock;
         bus.i_serdes_rx_hdr = vecs[i].hdr;
         bus.i_err_cnt_clr   = 1'b0;
         @(posedge clk);
         #1;
         chk_all($sformatf("vec%0d", i), vecs[i].ar, vecs[i].st, vecs[i].hb, vecs[i].rc, vecs[i].state);
      end
   endtask

   initial begin
      bus.i_rx_block_lock = 1'b0;
      bus.i_serdes_rx_hdr = 2'b01;
      bus.i_err_cnt_clr   = 1'b0;

      // vectors 0..12: reset, release, lock raised 10 cycles after release
      add_vec(1, 0, 2'b01, 1, 0, 0, 8'd0, S_RESET);
      add_vec(1, 0, 2'b01, 1, 0, 0, 8'd0, S_RESET);
      for (int i = 0; i < 3; i++) add_vec(0, 0, 2'b01, 1, 0, 0, 8'd0, S_RESET);
      for (int i = 3; i < 10; i++) add_vec(0, 0, 2'b01, 0, 0, 0, 8'd0, S_WAIT);
      add_vec(0, 1, 2'b01, 0, 1, 0, 8'd0, S_LOCKED);
      // vectors 13..18: mid-window reset, release with lock held high (ignored in RESET)
      add_vec(1, 1, 2'b11, 1, 0, 0, 8'd0, S_RESET);
      for (int i = 0; i < 3; i++) add_vec(0, 1, 2'b01, 1, 0, 0, 8'd0, S_RESET);
      add_vec(0, 1, 2'b01, 0, 0, 0, 8'd0, S_WAIT);
      add_vec(0, 1, 2'b01, 0, 1, 0, 8'd0, S_LOCKED);

      // bring-up and first lock
      apply_vecs(0, 12);
      chk_err("reset", 0);

      // 16 invalid headers in one window, then a clean window
      steps(15, 1, 2'b11);
      chk_all("ber15", 0, 1, 0, 8'd0, S_LOCKED);
      steps(1, 1, 2'b11);
      chk_all("ber16", 0, 0, 1, 8'd0, S_LOCKED);
      steps(48, 1, 2'b01);
      chk_all("win_a_end", 0, 0, 1, 8'd0, S_LOCKED);
      steps(63, 1, 2'b01);
      chk_all("win_b_last", 0, 0, 1, 8'd0, S_LOCKED);
      steps(1, 1, 2'b01);
      chk_all("win_b_end", 0, 1, 0, 8'd0, S_LOCKED);

      // 15 invalid per window never asserts hi_ber
      for (int i = 0; i < 64; i++) begin
         steps(1, 1, ((i % 4 == 0) && (i < 60)) ? 2'b11 : 2'b01);
         chk("win_c.high_ber", 32'(bus.o_rx_high_ber), 32'd0);
      end
      chk_all("win_c_end", 0, 1, 0, 8'd0, S_LOCKED);

      // 16th invalid header lands on the last window cycle
      steps(48, 1, 2'b01);
      steps(15, 1, 2'b11);
      chk_all("win_d_15", 0, 1, 0, 8'd0, S_LOCKED);
      steps(1, 1, 2'b11);
      chk_all("win_d_end", 0, 0, 1, 8'd0, S_LOCKED);
      // second consecutive hi_ber window forces an aligner reset
      steps(63, 1, 2'b11);
      chk_all("win_e_last", 0, 0, 1, 8'd0, S_LOCKED);
      steps(1, 1, 2'b01);
      chk_all("hiber_rst", 1, 0, 0, 8'd1, S_RESET);
      steps(3, 0, 2'b01);
      chk_all("hiber_rst_hold", 1, 0, 0, 8'd1, S_RESET);
      steps(1, 0, 2'b01);
      chk_all("hiber_rst_done", 0, 0, 0, 8'd1, S_WAIT);
      steps(1, 1, 2'b01);
      chk_all("relock", 0, 1, 0, 8'd1, S_LOCKED);

      // loss of lock while hi_ber: back to WAIT_LOCK without aligner reset
      steps(16, 1, 2'b11);
      chk_all("pre_loss", 0, 0, 1, 8'd1, S_LOCKED);
      steps(1, 0, 2'b01);
      chk_all("loss", 0, 0, 0, 8'd1, S_WAIT);
      steps(1, 1, 2'b01);
      chk_all("regain", 0, 1, 0, 8'd1, S_LOCKED);
      steps(5, 1, 2'b11);
      // reset in the middle of a BER window
      apply_vecs(13, 18);
      chk_err("mid_rst", 0);

      // error counter: 20 invalid, clear with a coincident invalid, then one more
      steps(20, 1, 2'b11);
      chk_err("err20", 20);
      steps(1, 1, 2'b11, 1'b1);
      chk_err("err_clr", 0);
      steps(1, 1, 2'b11);
      chk_err("err_after_clr", 1);

      // lock never arrives: periodic re-reset, relock count saturates
      i_rst = 1'b1;
      steps(1, 0, 2'b01);
      chk_all("to_reset", 1, 0, 0, 8'd0, S_RESET);
      chk_err("to_reset", 0);
      i_rst = 1'b0;
      for (int k = 1; k <= 258; k++) begin
         for (int p = 1; p <= 132; p++) begin
            steps(1, 0, 2'b01);
            chk($sformatf("to%0d_%0d.ar", k, p), 32'(bus.o_aligner_rst),
                32'((p <= 3) || (p == 132)));
            if (p == 131 || p == 132)
               chk($sformatf("to%0d_%0d.relock", k, p), 32'(bus.o_relock_count),
                   (p == 132) ? ((k > 255) ? 32'd255 : 32'(k)) : ((k - 1 > 255) ? 32'd255 : 32'(k - 1)));
         end
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

   // hard stop in case the stimulus ever stalls
   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected test completion");
      $fatal(1, "watchdog");
   end
endmodule
